window_fetch_sequencer: RTL and testbench
=========================================

WINDOW_FETCH_SEQUENCER -- requirements
Module: window_fetch_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, memory address width.
REQ-002 SHALL have parameter DIM_W, default 10, image width/height field width.
REQ-003 SHALL have port clk  input  1  system clock; one clock, all logic on its rising edge.
REQ-004 SHALL have port n_rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  one-cycle pulse, begins one image pass.
REQ-006 SHALL have port img_width, img_height  input  DIM_W each  image size in pixels, sampled on start.
REQ-007 SHALL have port src_base, dst_base  input  ADDR_W each  source/result base addresses, sampled on start.
REQ-008 SHALL have port mem_req  output  1  memory access request.
REQ-009 SHALL have port mem_wen  output  1  1 = write, 0 = read; valid with mem_req.
REQ-010 SHALL have port mem_addr  output  ADDR_W  access address; valid with mem_req.
REQ-011 SHALL have port mem_ack  input  1  one-cycle access completion.
REQ-012 SHALL have port pix_load  output  1  one-cycle pulse: read data on memory bus goes into window slot pix_slot.
REQ-013 SHALL have port pix_slot  output  4  window slot 0..8, slot = 3*col_offset + row_offset.
REQ-014 SHALL have port win_shift  output  1  one-cycle pulse: window shifts one column left (slots 3..8 -> 0..5).
REQ-015 SHALL have port calc_start  output  1  one-cycle pulse: window complete, gradient unit may compute.
REQ-016 SHALL have port calc_done  input  1  one-cycle pulse: edge result ready for writing.
REQ-017 SHALL have port busy, all_done, size_err  output  1 each  pass active; one-cycle end-of-pass pulse; sticky illegal-size flag.

Function
REQ-018 SHALL scan centre pixels (r,c), r = 1..H-2 outer, c = 1..W-2 inner; window rows r-1..r+1, columns c-1..c+1.
REQ-019 SHALL compute read address = src_base + row*W + col and write address = dst_base + r*W + c, modulo 2^ADDR_W.
REQ-020 SHALL implement states IDLE, LOAD9, LOAD3, CALC, WRITE, ADVANCE, DONE.
REQ-021 IDLE: on start with W>=3 and H>=3, latch parameters, set r=1, c=1, clear size_err, go to LOAD9; if W<3 or H<3, set size_err, pulse all_done next cycle, stay IDLE.
REQ-022 LOAD9: issue 9 reads in column-major order, col c-1..c+1, row r-1..r+1 within each column, slots 0..8; go to CALC after 9th ack.
REQ-023 LOAD3: pulse win_shift in the first LOAD3 cycle, no request that cycle; then issue 3 reads, column c+1, rows r-1..r+1, slots 6,7,8; go to CALC after 3rd ack.
REQ-024 Handshake: mem_req, mem_wen, mem_addr held stable until mem_ack is sampled high; at most one outstanding access; ack in the first request cycle allowed.
REQ-025 pix_load SHALL pulse in the mem_ack cycle of each read, with pix_slot valid that cycle.
REQ-026 CALC: pulse calc_start on the entry cycle; wait for calc_done; calc_done outside CALC ignored.
REQ-027 WRITE: request write (mem_wen=1) at the result address until ack, then go to ADVANCE.
REQ-028 ADVANCE (one cycle): c<W-2 -> c+1, go to LOAD3; else if r<H-2 -> c=1, r+1, go to LOAD9; else go to DONE.
REQ-029 DONE (one cycle): pulse all_done, go to IDLE.
REQ-030 busy SHALL be 1 in every state except IDLE.
REQ-031 start while busy SHALL be ignored; parameter inputs SHALL be ignored except on an accepted start.
REQ-032 mem_ack while mem_req=0 SHALL be ignored.

Reset
REQ-033 n_rst high at a clock edge SHALL force IDLE and set every output to 0 and r, c, latched parameters to 0, including mid-access; an ack in a later cycle is ignored.

Structure
REQ-034 State enum (fetch_state_t) and slot constants SHALL live in shared package sobel_pkg.
REQ-035 Address generation (row*W + col multiply-accumulate) SHALL be sub-module pixel_addr_gen, combinational or registered with at most one cycle latency absorbed before mem_req asserts.

Verification
REQ-036 3x3 image, src_base=0x100, dst_base=0x200, ack same cycle -> reads 0x100,0x103,0x106,0x101,0x104,0x107,0x102,0x105,0x108, slots 0..8; calc_start; write 0x204; all_done.
REQ-037 4x3 image, src_base=0 -> LOAD9 at 0,4,8,1,5,9,2,6,10; write 5; win_shift; reads 3,7,11 slots 6,7,8; write 6; all_done.
REQ-038 4x4 image -> after centre (1,2), LOAD9 restarts at column 0 row 1 (addresses 4,8,12,...); 4 writes total at dst+5,6,9,10.
REQ-039 mem_ack delayed 3 cycles per access -> mem_addr/mem_wen stable throughout, exactly one pix_load per ack.
REQ-040 start with img_width=2 -> no mem_req, size_err=1, all_done pulse, busy stays 0.
REQ-041 n_rst asserted during 5th LOAD9 read, then start on a 3x3 image -> all outputs 0 after reset; new pass from slot 0 at src_base.

Source files
------------

// File: rtl/sobel_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sobel_pkg
//  Description : Shared types and constants for the Sobel window fetch path:
//                fetch sequencer state encoding, 3x3 window slot constants
//                and the slot-number helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package sobel_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD9   = 3'd1,
        ST_LOAD3   = 3'd2,
        ST_CALC    = 3'd3,
        ST_WRITE   = 3'd4,
        ST_ADVANCE = 3'd5,
        ST_DONE    = 3'd6
    } fetch_state_t;

    // Window slot index width (slots 0..8).
    localparam int unsigned c_SLOT_W = 4;

    // Column/row offset inside the 3x3 window.
    localparam logic [1:0] c_OFF_FIRST = 2'd0;
    localparam logic [1:0] c_OFF_LAST  = 2'd2;

    // Smallest image dimension that still has a centre pixel.
    localparam int unsigned c_MIN_DIM = 3;

    // Slots are numbered column-major: slot = 3*col_offset + row_offset.
    function automatic logic [c_SLOT_W-1:0] slot_of(input logic [1:0] col_off,
                                                    input logic [1:0] row_off);
        slot_of = ({2'b00, col_off} * 4'd3) + {2'b00, row_off};
    endfunction

endpackage
`default_nettype wire

// File: rtl/window_fetch_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : window_fetch_sequencer_if
//  Description : Control/memory bus of the window fetch sequencer.
//                master : sequencer side (drives mem_*, pix_*, win_shift,
//                         calc_start, busy, all_done, size_err)
//                slave  : environment side (drives start, image parameters,
//                         mem_ack, calc_done)
//  Revision    : 1.0 - initial release
// ============================================================================
interface window_fetch_sequencer_if
    import sobel_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 10
);
    logic                start;
    logic [DIM_W-1:0]    img_width;
    logic [DIM_W-1:0]    img_height;
    logic [ADDR_W-1:0]   src_base;
    logic [ADDR_W-1:0]   dst_base;
    logic                mem_req;
    logic                mem_wen;
    logic [ADDR_W-1:0]   mem_addr;
    logic                mem_ack;
    logic                pix_load;
    logic [c_SLOT_W-1:0] pix_slot;
    logic                win_shift;
    logic                calc_start;
    logic                calc_done;
    logic                busy;
    logic                all_done;
    logic                size_err;

    modport master (
        input  start, img_width, img_height, src_base, dst_base, mem_ack, calc_done,
        output mem_req, mem_wen, mem_addr, pix_load, pix_slot, win_shift,
               calc_start, busy, all_done, size_err
    );

    modport slave (
        output start, img_width, img_height, src_base, dst_base, mem_ack, calc_done,
        input  mem_req, mem_wen, mem_addr, pix_load, pix_slot, win_shift,
               calc_start, busy, all_done, size_err
    );

endinterface
`default_nettype wire

// File: rtl/pixel_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pixel_addr_gen
//  Description : Combinational pixel address: o_addr = i_base + i_row*i_width
//                + i_col, wrapping modulo 2^ADDR_W.
//  Ports       : i_base  - image base address
//                i_width - image width in pixels
//                i_row   - pixel row
//                i_col   - pixel column
//                o_addr  - resulting memory address
//  Revision    : 1.0 - initial release
// ============================================================================
module pixel_addr_gen
    import sobel_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 10
) (
    input  wire logic [ADDR_W-1:0] i_base,
    input  wire logic [DIM_W-1:0]  i_width,
    input  wire logic [DIM_W-1:0]  i_row,
    input  wire logic [DIM_W-1:0]  i_col,
    output logic      [ADDR_W-1:0] o_addr
);

    logic [2*DIM_W-1:0] w_prod;

    assign w_prod = (2*DIM_W)'(i_row) * (2*DIM_W)'(i_width);
    // Truncating/extending every term to ADDR_W gives the modulo wrap directly.
    assign o_addr = i_base + ADDR_W'(w_prod) + ADDR_W'(i_col);

endmodule
`default_nettype wire

// File: rtl/window_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : window_fetch_sequencer
//  Description : Walks every interior pixel of an image, fetching its 3x3
//                neighbourhood into the window (9 reads for the first centre
//                of a row, shift + 3 reads afterwards), triggers the gradient
//                unit and writes the result back.
//  Ports       : clk   - system clock, rising edge
//                n_rst - synchronous active-high reset
//                bus   - master side of window_fetch_sequencer_if
//                        (start/parameters, memory handshake, window control,
//                        gradient handshake, status)
//  Revision    : 1.0 - initial release
// ============================================================================
module window_fetch_sequencer
    import sobel_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 10
) (
    input wire logic                 clk,
    input wire logic                 n_rst,
    window_fetch_sequencer_if.master bus
);

    fetch_state_t        r_state;
    logic [DIM_W-1:0]    r_width;
    logic [DIM_W-1:0]    r_height;
    logic [ADDR_W-1:0]   r_src;
    logic [ADDR_W-1:0]   r_dst;
    logic [DIM_W-1:0]    r_row;
    logic [DIM_W-1:0]    r_col;
    logic [1:0]          r_col_off;
    logic [1:0]          r_row_off;
    logic                r_mem_req;
    logic                r_mem_wen;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [c_SLOT_W-1:0] r_pix_slot;
    logic                r_win_shift;
    logic                r_calc_start;
    logic                r_busy;
    logic                r_all_done;
    logic                r_size_err;

    logic                w_is_write;
    logic                w_accept;
    logic                w_last_pix;
    logic                w_size_bad;
    logic [ADDR_W-1:0]   w_base;
    logic [DIM_W-1:0]    w_row;
    logic [DIM_W-1:0]    w_col;
    logic [ADDR_W-1:0]   w_addr;

    // Reads address the window pixel (r-1+row_off, c-1+col_off) in the source
    // image; the write addresses the centre pixel in the result image.
    assign w_is_write = (r_state == ST_WRITE);
    assign w_base     = w_is_write ? r_dst : r_src;
    assign w_row      = w_is_write ? r_row : (r_row - DIM_W'(1) + DIM_W'(r_row_off));
    assign w_col      = w_is_write ? r_col : (r_col - DIM_W'(1) + DIM_W'(r_col_off));

    pixel_addr_gen #(
        .ADDR_W (ADDR_W),
        .DIM_W  (DIM_W)
    ) u_addr_gen (
        .i_base  (w_base),
        .i_width (r_width),
        .i_row   (w_row),
        .i_col   (w_col),
        .o_addr  (w_addr)
    );

    // An ack only counts while a request is actually outstanding.
    assign w_accept   = r_mem_req & bus.mem_ack;
    assign w_last_pix = (r_col_off == c_OFF_LAST) && (r_row_off == c_OFF_LAST);
    assign w_size_bad = (bus.img_width < DIM_W'(c_MIN_DIM)) ||
                        (bus.img_height < DIM_W'(c_MIN_DIM));

    always_ff @(posedge clk) begin
        if (n_rst) begin
            r_state      <= ST_IDLE;
            r_width      <= '0;
            r_height     <= '0;
            r_src        <= '0;
            r_dst        <= '0;
            r_row        <= '0;
            r_col        <= '0;
            r_col_off    <= c_OFF_FIRST;
            r_row_off    <= c_OFF_FIRST;
            r_mem_req    <= 1'b0;
            r_mem_wen    <= 1'b0;
            r_mem_addr   <= '0;
            r_pix_slot   <= '0;
            r_win_shift  <= 1'b0;
            r_calc_start <= 1'b0;
            r_busy       <= 1'b0;
            r_all_done   <= 1'b0;
            r_size_err   <= 1'b0;
        end else begin
            r_win_shift  <= 1'b0;
            r_calc_start <= 1'b0;
            r_all_done   <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (w_size_bad) begin
                            r_size_err <= 1'b1;
                            r_all_done <= 1'b1;
                        end else begin
                            r_width    <= bus.img_width;
                            r_height   <= bus.img_height;
                            r_src      <= bus.src_base;
                            r_dst      <= bus.dst_base;
                            r_row      <= DIM_W'(1);
                            r_col      <= DIM_W'(1);
                            r_col_off  <= c_OFF_FIRST;
                            r_row_off  <= c_OFF_FIRST;
                            r_size_err <= 1'b0;
                            r_busy     <= 1'b1;
                            r_state    <= ST_LOAD9;
                        end
                    end
                end

                ST_LOAD9, ST_LOAD3: begin
                    if (!r_mem_req) begin
                        // The win_shift cycle at LOAD3 entry must not overlap a read.
                        if (!((r_state == ST_LOAD3) && r_win_shift)) begin
                            r_mem_req  <= 1'b1;
                            r_mem_wen  <= 1'b0;
                            r_mem_addr <= w_addr;
                            r_pix_slot <= slot_of(r_col_off, r_row_off);
                        end
                    end else if (w_accept) begin
                        r_mem_req <= 1'b0;
                        if (w_last_pix) begin
                            r_calc_start <= 1'b1;
                            r_state      <= ST_CALC;
                        end else if (r_row_off == c_OFF_LAST) begin
                            r_row_off <= c_OFF_FIRST;
                            r_col_off <= r_col_off + 2'd1;
                        end else begin
                            r_row_off <= r_row_off + 2'd1;
                        end
                    end
                end

                ST_CALC: begin
                    if (bus.calc_done) begin
                        r_state <= ST_WRITE;
                    end
                end

                ST_WRITE: begin
                    if (!r_mem_req) begin
                        r_mem_req  <= 1'b1;
                        r_mem_wen  <= 1'b1;
                        r_mem_addr <= w_addr;
                    end else if (w_accept) begin
                        r_mem_req <= 1'b0;
                        r_mem_wen <= 1'b0;
                        r_state   <= ST_ADVANCE;
                    end
                end

                ST_ADVANCE: begin
                    r_row_off <= c_OFF_FIRST;
                    if (r_col < (r_width - DIM_W'(2))) begin
                        // Same row: only the new right-hand column is fetched.
                        r_col       <= r_col + DIM_W'(1);
                        r_col_off   <= c_OFF_LAST;
                        r_win_shift <= 1'b1;
                        r_state     <= ST_LOAD3;
                    end else if (r_row < (r_height - DIM_W'(2))) begin
                        r_col     <= DIM_W'(1);
                        r_row     <= r_row + DIM_W'(1);
                        r_col_off <= c_OFF_FIRST;
                        r_state   <= ST_LOAD9;
                    end else begin
                        r_all_done <= 1'b1;
                        r_state    <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req    = r_mem_req;
    assign bus.mem_wen    = r_mem_wen;
    assign bus.mem_addr   = r_mem_addr;
    // Read data is on the bus during the ack cycle itself.
    assign bus.pix_load   = w_accept & ~r_mem_wen;
    assign bus.pix_slot   = r_pix_slot;
    assign bus.win_shift  = r_win_shift;
    assign bus.calc_start = r_calc_start;
    assign bus.busy       = r_busy;
    assign bus.all_done   = r_all_done;
    assign bus.size_err   = r_size_err;

endmodule
`default_nettype wire

// File: tb/tb_window_fetch_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_window_fetch_sequencer
//  Description : Self-checking bench. A reference model expands each image
//                pass into the ordered list of bus events (reads with slot,
//                window shifts, calc starts, writes, end-of-pass) and every
//                observed event is compared against it. Memory and gradient
//                responders use random latencies and inject stray acks,
//                stray calc_done and ignored start pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_window_fetch_sequencer;
    import sobel_pkg::*;

    localparam int ADDR_W = 16;
    localparam int DIM_W  = 10;

    localparam int c_EV_RD    = 1;
    localparam int c_EV_WR    = 2;
    localparam int c_EV_SHIFT = 3;
    localparam int c_EV_CALC  = 4;
    localparam int c_EV_DONE  = 5;

    logic clk = 1'b0;
    logic n_rst;

    always #5 clk = ~clk;

    window_fetch_sequencer_if #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) bus ();

    window_fetch_sequencer #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];

    int          ack_wait  = -1;
    int          calc_wait = -1;
    int          max_delay = 0;
    bit          fixed_delay = 1'b1;
    bit          noise       = 1'b0;
    bit          pass_active = 1'b0;
    bit          done_seen   = 1'b0;
    bit          do_start    = 1'b0;
    int          reads_acked = 0;
    bit          prev_pend   = 1'b0;
    logic        prev_wen;
    logic [15:0] prev_addr;
    int          p_w, p_h;
    logic [15:0] p_src, p_dst;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] ev(input int kind, input logic [3:0] slot, input logic [15:0] addr);
        logic [7:0] k;
        k = kind[7:0];
        return {k, 4'h0, slot, addr};
    endfunction

    function automatic logic [31:0] outs();
        return {4'd0, bus.mem_req, bus.mem_wen, bus.mem_addr, bus.pix_load, bus.pix_slot,
                bus.win_shift, bus.calc_start, bus.busy, bus.all_done, bus.size_err};
    endfunction

    function automatic logic [15:0] addr_of(input logic [15:0] base, input int row, input int col, input int w);
        int sum;
        sum = int'(base) + row * w + col;
        return sum[15:0];
    endfunction

    // Reference: every centre (r,c) in raster order; the first centre of a
    // row needs the full 3x3 window, later ones shift and fetch column c+1.
    task automatic build_model(input int w, input int h, input logic [15:0] src, input logic [15:0] dst);
        for (int r = 1; r <= h - 2; r++) begin
            for (int c = 1; c <= w - 2; c++) begin
                if (c == 1) begin
                    for (int dc = 0; dc < 3; dc++)
                        for (int dr = 0; dr < 3; dr++)
                            exp_q.push_back(ev(c_EV_RD, 4'(dc * 3 + dr), addr_of(src, r - 1 + dr, c - 1 + dc, w)));
                end else begin
                    exp_q.push_back(ev(c_EV_SHIFT, 4'd0, 16'd0));
                    for (int dr = 0; dr < 3; dr++)
                        exp_q.push_back(ev(c_EV_RD, 4'(6 + dr), addr_of(src, r - 1 + dr, c + 1, w)));
                end
                exp_q.push_back(ev(c_EV_CALC, 4'd0, 16'd0));
                exp_q.push_back(ev(c_EV_WR, 4'd0, addr_of(dst, r, c, w)));
            end
        end
        exp_q.push_back(ev(c_EV_DONE, 4'd0, 16'd0));
    endtask

    task automatic observe(input logic [31:0] obs);
        if (exp_q.size() == 0) check_eq("extra_event", obs, 32'd0);
        else check_eq("event", obs, exp_q.pop_front());
        if (pass_active) check_eq("busy_in_pass", 32'(bus.busy), 32'd1);
    endtask

    task automatic cycle();
        logic acc, rd;
        @(negedge clk);
        // memory responder
        bus.mem_ack = 1'b0;
        if (bus.mem_req) begin
            if (ack_wait < 0) ack_wait = fixed_delay ? max_delay : int'($urandom_range(0, max_delay));
            if (ack_wait == 0) begin
                bus.mem_ack = 1'b1;
                ack_wait = -1;
            end else ack_wait--;
        end else if (noise && $urandom_range(0, 3) == 0) bus.mem_ack = 1'b1;
        // gradient unit responder
        bus.calc_done = 1'b0;
        if (bus.calc_start) calc_wait = int'($urandom_range(0, 3));
        if (calc_wait == 0) begin
            bus.calc_done = 1'b1;
            calc_wait = -1;
        end else if (calc_wait > 0) calc_wait--;
        else if (noise && $urandom_range(0, 3) == 0) bus.calc_done = 1'b1;
        // start / parameters
        bus.start = 1'b0;
        if (do_start) begin
            bus.start = 1'b1;
            bus.img_width  = DIM_W'(p_w);
            bus.img_height = DIM_W'(p_h);
            bus.src_base   = p_src;
            bus.dst_base   = p_dst;
            do_start = 1'b0;
        end else if (noise && pass_active && $urandom_range(0, 7) == 0) begin
            bus.start = 1'b1;
            bus.img_width  = DIM_W'($urandom_range(0, 20));
            bus.img_height = DIM_W'($urandom_range(0, 20));
            bus.src_base   = 16'($urandom);
            bus.dst_base   = 16'($urandom);
        end
        #1;
        // monitor
        if (prev_pend)
            check_eq("req_hold", {14'd0, bus.mem_req, bus.mem_wen, bus.mem_addr},
                     {14'd0, 1'b1, prev_wen, prev_addr});
        acc = bus.mem_req && bus.mem_ack;
        rd  = acc && !bus.mem_wen;
        if (rd || bus.pix_load) check_eq("pix_load", 32'(bus.pix_load), 32'(rd));
        prev_pend = bus.mem_req && !bus.mem_ack;
        prev_wen  = bus.mem_wen;
        prev_addr = bus.mem_addr;
        if (rd) begin
            reads_acked++;
            observe(ev(c_EV_RD, bus.pix_slot, bus.mem_addr));
        end else if (acc) observe(ev(c_EV_WR, 4'd0, bus.mem_addr));
        if (bus.win_shift)  observe(ev(c_EV_SHIFT, 4'd0, 16'd0));
        if (bus.calc_start) observe(ev(c_EV_CALC, 4'd0, 16'd0));
        if (bus.all_done) begin
            observe(ev(c_EV_DONE, 4'd0, 16'd0));
            done_seen   = 1'b1;
            pass_active = 1'b0;
        end
    endtask

    task automatic run_pass(input int w, input int h, input logic [15:0] src, input logic [15:0] dst);
        bit good;
        int budget;
        good = (w >= 3) && (h >= 3);
        if (good) build_model(w, h, src, dst);
        else exp_q.push_back(ev(c_EV_DONE, 4'd0, 16'd0));
        p_w = w; p_h = h; p_src = src; p_dst = dst;
        do_start  = 1'b1;
        done_seen = 1'b0;
        cycle();
        pass_active = good;
        budget = 0;
        while (!done_seen && budget < 3000) begin
            cycle();
            budget++;
            if (!good) check_eq("bad_size_idle", {30'd0, bus.mem_req, bus.busy}, 32'd0);
        end
        check_eq("model_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        pass_active = 1'b0;
        cycle();
        check_eq("busy_after", 32'(bus.busy), 32'd0);
        check_eq("size_err", 32'(bus.size_err), 32'(!good));
    endtask

    task automatic reset_test();
        int guard;
        noise = 1'b0; fixed_delay = 1'b1; max_delay = 3;
        build_model(4, 4, 16'h0010, 16'h0060);
        p_w = 4; p_h = 4; p_src = 16'h0010; p_dst = 16'h0060;
        do_start = 1'b1; done_seen = 1'b0; reads_acked = 0;
        cycle();
        pass_active = 1'b1;
        guard = 0;
        while (!(reads_acked == 4 && bus.mem_req && !bus.mem_ack) && guard < 500) begin
            cycle();
            guard++;
        end
        check_eq("rst_reach", 32'(reads_acked), 32'd4);
        n_rst = 1'b1;
        bus.mem_ack = 1'b0;
        @(negedge clk);
        #1;
        check_eq("rst_outs", outs(), 32'd0);
        n_rst = 1'b0;
        bus.mem_ack = 1'b1;          // late ack of the aborted read
        exp_q.delete();
        pass_active = 1'b0; ack_wait = -1; calc_wait = -1; prev_pend = 1'b0;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        #1;
        check_eq("rst_late_ack", outs(), 32'd0);
        run_pass(3, 3, 16'h0100, 16'h0200);
    endtask

    initial begin
        n_rst = 1'b1;
        bus.start = 1'b0; bus.mem_ack = 1'b0; bus.calc_done = 1'b0;
        bus.img_width = '0; bus.img_height = '0; bus.src_base = '0; bus.dst_base = '0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("reset_outs", outs(), 32'd0);
        n_rst = 1'b0;

        fixed_delay = 1'b1; max_delay = 0;
        run_pass(3, 3, 16'h0100, 16'h0200);
        run_pass(4, 3, 16'h0000, 16'h0040);
        run_pass(4, 4, 16'h0000, 16'h0080);
        max_delay = 3;
        run_pass(5, 4, 16'h0030, 16'h0090);

        max_delay = 0;
        run_pass(2, 5, 16'h0011, 16'h0022);
        run_pass(6, 1, 16'h0011, 16'h0022);
        run_pass(0, 0, 16'h0011, 16'h0022);

        noise = 1'b1; fixed_delay = 1'b0; max_delay = 3;
        for (int i = 0; i < 8; i++)
            run_pass(int'($urandom_range(3, 7)), int'($urandom_range(3, 6)),
                     (i == 0) ? 16'hFFF0 : 16'($urandom), 16'($urandom));

        reset_test();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
